// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
package seg_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex digit (entry F listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex-to-seven-segment lookup, active-low segments.
module seven_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[digit];

endmodule

// File: rtl/seg_mux_driver.sv
// Two-digit multiplexed seven-segment driver with blanking gaps between slots.
// Optional macro LEADING_ZERO_BLANK_EN turns a zero on digit 1 into a dark slot.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int SHOW_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic       an0,
  output logic       an1,
  output logic       frame
);

  localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       d0, d1, d0_nx, d1_nx, digit_sel;
  logic [6:0]       dec_seg, seg_nx;
  logic             an0_nx, an1_nx, frame_nx, advance;

  seven_seg_decoder u_dec (
    .digit (digit_sel),
    .seg   (dec_seg)
  );

  // Next-state, capture and output decode are all computed from the state being
  // entered, so the registered outputs switch on the same edge as the state.
  always_comb begin
    advance  = (cnt == '0);
    state_nx = state;
    cnt_nx   = cnt - CNT_W'(1);
    if (advance) begin
      case (state)
        SHOW0:   state_nx = HAS_BLANK ? BLANK0 : SHOW1;
        BLANK0:  state_nx = SHOW1;
        SHOW1:   state_nx = HAS_BLANK ? BLANK1 : SHOW0;
        default: state_nx = SHOW0;
      endcase
      cnt_nx = (state_nx == SHOW0 || state_nx == SHOW1) ? SHOW_LD : BLANK_LD;
    end

    d0_nx     = (advance && state_nx == SHOW0) ? s0 : d0;
    d1_nx     = (advance && state_nx == SHOW1) ? s1 : d1;
    digit_sel = (state_nx == SHOW1) ? d1_nx : d0_nx;

    seg_nx   = SEG_OFF;
    an0_nx   = 1'b1;
    an1_nx   = 1'b1;
    frame_nx = advance && (state_nx == SHOW0);
    case (state_nx)
      SHOW0: begin
        seg_nx = dec_seg;
        an0_nx = 1'b0;
      end
      SHOW1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (d1_nx != 4'd0) begin
          seg_nx = dec_seg;
          an1_nx = 1'b0;
        end
`else
        seg_nx = dec_seg;
        an1_nx = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK1;
      cnt   <= '0;
      d0    <= 4'd0;
      d1    <= 4'd0;
      seg   <= SEG_OFF;
      an0   <= 1'b1;
      an1   <= 1'b1;
      frame <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      d0    <= d0_nx;
      d1    <= d1_nx;
      seg   <= seg_nx;
      an0   <= an0_nx;
      an1   <= an1_nx;
      frame <= frame_nx;
    end
  end

endmodule
